rf_wb_queue: RTL and testbench

//  Writeback side of the 32x32 register file. Accepts result writes from two producers: ALU and load unit.

---
 rtl/rf_wb_queue.sv | 127 ++++++++++++
 tb/tb_rf_wb_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order writeback queue from the ALU and load unit to the register file write port.
// Latency: a write accepted at edge N into an empty queue drives WE/A3/WD3 from edge N+1.
// Backpressure: ready depends on current occupancy only, and the load wins the last free slot. Requests with rd==0 are always ready and dropped.
// Optional macro WB_FWD_EN: when defined, chk_data forwards the youngest queued data for chk_addr. Otherwise chk_data is 0.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          WE,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_pending,
    output logic [DW-1:0] chk_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0]    rd_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    alu_slot;
    logic [CW-1:0]    free;
    logic             mem_eff;
    logic             alu_eff;
    logic             mem_enq;
    logic             alu_enq;
    logic             pop;
    logic [DEPTH-1:0] hit;

    assign free    = CW'(DEPTH) - count;
    assign mem_eff = mem_valid & (mem_rd != '0);
    assign alu_eff = alu_valid & (alu_rd != '0);

    // The load gets the last slot; the ALU needs two free, or one free with no competing load.
    assign mem_ready = (free >= CW'(1)) | (mem_rd == '0);
    assign alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~mem_eff) | (alu_rd == '0);

    assign mem_enq  = mem_eff & mem_ready;
    assign alu_enq  = alu_eff & alu_ready;
    assign pop      = (count != '0);
    assign alu_slot = tail + PW'(mem_enq);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // Pointer and occupancy bookkeeping; a reset discards everything still queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(mem_enq) + PW'(alu_enq);
            count <= count + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);
        end
    end

    // Entry storage: the load takes the tail slot first so it is older than a same-cycle ALU write.
    always_ff @(posedge clk) begin
        if (mem_enq) begin
            rd_q[tail]   <= mem_rd;
            data_q[tail] <= mem_data;
        end
        if (alu_enq) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    // Register-file write port: present the popped head for one cycle, hold address/data otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE  <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            WE <= pop;
            if (pop) begin
                A3  <= rd_q[head];
                WD3 <= data_q[head];
            end
        end
    end

    // Per-slot match over occupied entries only, indexed by age (bit 0 = oldest).
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (chk_addr != '0) && (rd_q[head + PW'(i)] == chk_addr)) begin
                hit[i] = 1'b1;
            end
        end
    end

    assign chk_pending = |hit;

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the last match, the youngest write, wins.
    always_comb begin
        chk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                chk_data = data_q[head + PW'(i)];
            end
        end
    end
`else
    assign chk_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
module tb_rf_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_rd, mem_rd, chk_addr, A3;
    logic [DW-1:0] alu_data, mem_data, WD3, chk_data;
    logic          WE, chk_pending, full, empty;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model: the queue contents plus the expected write-port registers.
    ent_t          mq[$];
    logic          exp_we;
    logic [AW-1:0] exp_a3;
    logic [DW-1:0] exp_wd3;

    rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .WE(WE), .A3(A3), .WD3(WD3),
        .chk_addr(chk_addr), .chk_pending(chk_pending), .chk_data(chk_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int m_free();
        return DEPTH - mq.size();
    endfunction

    function automatic bit m_mem_ready();
        return (m_free() >= 1) || (mem_rd == 0);
    endfunction

    function automatic bit m_alu_ready();
        bit load_wants = mem_valid && (mem_rd != 0);
        return (m_free() >= 2) || (m_free() == 1 && !load_wants) || (alu_rd == 0);
    endfunction

    function automatic bit m_pending();
        if (chk_addr == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == chk_addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] m_fwd();
`ifdef WB_FWD_EN
        if (chk_addr != 0)
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].rd == chk_addr) return mq[i].data;
`endif
        return '0;
    endfunction

    function automatic void m_clear();
        mq.delete();
        exp_we  = 1'b0;
        exp_a3  = '0;
        exp_wd3 = '0;
    endfunction

    // Advance the model over one clock edge using the currently driven inputs, then step the DUT.
    task automatic tick();
        bit   mr, ar, me, ae;
        ent_t e;
        me = mem_valid && (mem_rd != 0);
        ae = alu_valid && (alu_rd != 0);
        mr = m_mem_ready();
        ar = m_alu_ready();
        if (mq.size() > 0) begin
            e       = mq.pop_front();
            exp_we  = 1'b1;
            exp_a3  = e.rd;
            exp_wd3 = e.data;
        end else begin
            exp_we = 1'b0;
        end
        if (me && mr) mq.push_back('{rd: mem_rd, data: mem_data});
        if (ae && ar) mq.push_back('{rd: alu_rd, data: alu_data});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (WE !== 1'b0)     begin failures++; $display("FAIL reset_we got=%b exp=0", WE); end
        checks++; if (A3 !== '0)       begin failures++; $display("FAIL reset_a3 got=%0d exp=0", A3); end
        checks++; if (WD3 !== '0)      begin failures++; $display("FAIL reset_wd3 got=%h exp=0", WD3); end
        checks++; if (count !== '0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)   begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        rst = 1'b0;
        m_clear();
        alu_rd = 5'd3; mem_rd = 5'd4;
        #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b%b exp=11", alu_ready, mem_ready); end
        @(posedge clk); #1;
        // Put one write on the port, then reset between edges.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        tick();
        idle_inputs();
        tick();
        checks++; if (WE !== 1'b1) begin failures++; $display("FAIL pre_reset_we got=%b exp=1", WE); end
        #2 rst = 1'b1;
        #1;
        checks++; if (WE !== 1'b0) begin failures++; $display("FAIL async_reset_we got=%b exp=0", WE); end
        checks++; if (empty !== 1'b1 || count !== '0) begin
            failures++; $display("FAIL async_reset_occ got=%0d/%b exp=0/1", count, empty); end
        #1 rst = 1'b0;
        m_clear();
        #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_ready got=%b%b exp=11", alu_ready, mem_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", alu_ready); end
        tick();
        idle_inputs();
        checks++; if (count !== 3'd1 || WE !== 1'b0) begin
            failures++; $display("FAIL single_queued got=cnt%0d/we%b exp=cnt1/we0", count, WE); end
        tick();
        checks++; if (WE !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", WE, A3, WD3); end
        tick();
        checks++; if (WE !== 1'b0 || A3 !== 5'd5) begin
            failures++; $display("FAIL single_after got=%b/%0d exp=0/5", WE, A3); end
    endtask

    task automatic test_both_producers();
        logic [AW-1:0] ord [8];
        int  mi = 0, ai = 0, wi = 0;
        bit  am, aa, saw_hold = 0;
        ord = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd4, 5'd13, 5'd14};
        for (int cyc = 0; cyc < 20; cyc++) begin
            mem_valid = (mi < 4); mem_rd = AW'(mi + 1);  mem_data = 32'hC000_0000 + mi;
            alu_valid = (ai < 4); alu_rd = AW'(ai + 11); alu_data = 32'hA000_0000 + ai;
            #1;
            checks++; if (alu_ready !== m_alu_ready() || mem_ready !== m_mem_ready()) begin
                failures++; $display("FAIL both_ready cyc=%0d got=%b%b exp=%b%b",
                                     cyc, alu_ready, mem_ready, m_alu_ready(), m_mem_ready()); end
            if (mem_valid && m_free() == 1) begin
                saw_hold = 1;
                checks++; if (alu_ready !== 1'b0) begin
                    failures++; $display("FAIL both_alu_hold cyc=%0d got=%b exp=0", cyc, alu_ready); end
            end
            checks++; if (full !== (mq.size() == DEPTH)) begin
                failures++; $display("FAIL both_full cyc=%0d got=%b exp=%b", cyc, full, mq.size() == DEPTH); end
            am = mem_valid && m_mem_ready();
            aa = alu_valid && m_alu_ready();
            tick();
            if (am) mi++;
            if (aa) ai++;
            if (WE) begin
                checks++;
                if (wi >= 8) begin
                    failures++; $display("FAIL both_extra_write got=%0d exp=none", A3);
                end else if (A3 !== ord[wi] || WD3 !== exp_wd3) begin
                    failures++; $display("FAIL both_order idx=%0d got=%0d/%h exp=%0d/%h", wi, A3, WD3, ord[wi], exp_wd3);
                end
                wi++;
            end
        end
        idle_inputs();
        checks++; if (wi != 8) begin failures++; $display("FAIL both_write_count got=%0d exp=8", wi); end
        checks++; if (!saw_hold) begin failures++; $display("FAIL both_no_hold got=0 exp=1"); end
    endtask

    task automatic test_rd_zero();
        mem_valid = 1'b1; mem_rd = '0; mem_data = 32'h0000_1234;
        #1;
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL rd0_ready got=%b exp=1", mem_ready); end
        tick();
        idle_inputs();
        checks++; if (count !== '0) begin failures++; $display("FAIL rd0_count got=%0d exp=0", count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (WE !== 1'b0) begin failures++; $display("FAIL rd0_we cyc=%0d got=%b exp=0", i, WE); end
        end
    endtask

    task automatic test_hazard();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hB;
        chk_addr = 5'd7;
        tick();
        idle_inputs();
        #1;
        checks++; if (chk_pending !== 1'b1) begin failures++; $display("FAIL haz_pending2 got=%b exp=1", chk_pending); end
`ifdef WB_FWD_EN
        checks++; if (chk_data !== 32'hB) begin failures++; $display("FAIL haz_fwd2 got=%h exp=b", chk_data); end
`else
        checks++; if (chk_data !== 32'h0) begin failures++; $display("FAIL haz_fwd2 got=%h exp=0", chk_data); end
`endif
        chk_addr = '0;
        #1;
        checks++; if (chk_pending !== 1'b0) begin failures++; $display("FAIL haz_addr0 got=%b exp=0", chk_pending); end
        chk_addr = 5'd7;
        tick();
        #1;
        checks++; if (chk_pending !== 1'b1 || chk_data !== m_fwd()) begin
            failures++; $display("FAIL haz_pending1 got=%b/%h exp=1/%h", chk_pending, chk_data, m_fwd()); end
        tick();
        #1;
        checks++; if (WE !== 1'b1 || WD3 !== 32'hB || chk_pending !== 1'b0) begin
            failures++; $display("FAIL haz_drained got=%b/%h/%b exp=1/b/0", WE, WD3, chk_pending); end
        chk_addr = '0;
        @(posedge clk); #1;
        m_clear();
        exp_a3 = 5'd7; exp_wd3 = 32'hB;
    endtask

    task automatic test_reset_mid_drain();
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        tick();
        mem_rd = 5'd4; mem_data = 32'h44; alu_rd = 5'd5; alu_data = 32'h55;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd3 || WE !== 1'b1) begin
            failures++; $display("FAIL drain_pre got=cnt%0d/we%b exp=cnt3/we1", count, WE); end
        #2 rst = 1'b1;
        #1;
        checks++; if (WE !== 1'b0 || count !== '0 || empty !== 1'b1 || A3 !== '0) begin
            failures++; $display("FAIL drain_async got=%b/%0d/%b/%0d exp=0/0/1/0", WE, count, empty, A3); end
        #1 rst = 1'b0;
        m_clear();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (WE !== 1'b0) begin failures++; $display("FAIL drain_stale cyc=%0d got=%b exp=0", i, WE); end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            mem_valid = ($urandom_range(0, 9) < 7);
            mem_rd    = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 7));
            mem_data  = $urandom;
            alu_valid = ($urandom_range(0, 9) < 7);
            alu_rd    = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 7));
            alu_data  = $urandom;
            chk_addr  = AW'($urandom_range(0, 7));
            #1;
            checks++; if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
                failures++; $display("FAIL rnd_occ cyc=%0d got=%0d/%b/%b exp=%0d", cyc, count, full, empty, mq.size()); end
            checks++; if (mem_ready !== m_mem_ready() || alu_ready !== m_alu_ready()) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b",
                                     cyc, mem_ready, alu_ready, m_mem_ready(), m_alu_ready()); end
            checks++; if (chk_pending !== m_pending() || chk_data !== m_fwd()) begin
                failures++; $display("FAIL rnd_chk cyc=%0d got=%b/%h exp=%b/%h",
                                     cyc, chk_pending, chk_data, m_pending(), m_fwd()); end
            tick();
            checks++; if (WE !== exp_we || A3 !== exp_a3 || WD3 !== exp_wd3) begin
                failures++; $display("FAIL rnd_port cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h",
                                     cyc, WE, A3, WD3, exp_we, exp_a3, exp_wd3); end
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();
        checks++; if (empty !== 1'b1 || WE !== 1'b0) begin
            failures++; $display("FAIL rnd_final got=%b/%b exp=1/0", empty, WE); end
    endtask

    initial begin
        idle_inputs();
        chk_addr = '0;
        m_clear();
        test_reset();
        test_single_write();
        test_both_producers();
        test_rd_zero();
        test_hazard();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
